// File: rtl/song_sequencer.sv
// rtl/song_sequencer.sv - transport controller for the record/playback path
// Turns button pulses and song switches into address-calculator controls.
module song_sequencer #(
    parameter int COUNTIN_READY = 96000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ready,
    input  logic       btn_play,
    input  logic       btn_record,
    input  logic       btn_pause,
    input  logic       btn_stop,
    input  logic [3:0] sw_song,
    input  logic       sw_loop,
    input  logic       song_done,
    output logic       start_song,
    output logic       pause_song,
    output logic       record_mode,
    output logic [3:0] song_choice,
    output logic       we,
    output logic       count_in,
    output logic       song_finished,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COUNTIN = 3'd1,
        S_START   = 3'd2,
        S_RUN     = 3'd3,
        S_PAUSED  = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [16:0] CNT_LAST = 17'(COUNTIN_READY - 1);

    state_t      state_q, state_d;
    logic [3:0]  song_choice_q, song_choice_d;
    logic        record_mode_q, record_mode_d;
    logic [16:0] cnt_q, cnt_d;
    logic        code_ok;

    // Song codes whose low three bits are 6 or 7 do not exist.
    assign code_ok = (sw_song[2:1] != 2'b11);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            song_choice_q <= 4'd0;
            record_mode_q <= 1'b0;
            cnt_q         <= 17'd0;
        end else begin
            state_q       <= state_d;
            song_choice_q <= song_choice_d;
            record_mode_q <= record_mode_d;
            cnt_q         <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        song_choice_d = song_choice_q;
        record_mode_d = record_mode_q;
        cnt_d         = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (btn_record && code_ok) begin
                    song_choice_d = sw_song;
                    record_mode_d = 1'b1;
                    cnt_d         = 17'd0;
                    state_d       = S_COUNTIN;
                end else if (btn_play && code_ok) begin
                    song_choice_d = sw_song;
                    record_mode_d = 1'b0;
                    state_d       = S_START;
                end
            end
            S_COUNTIN: begin
                if (btn_stop) begin
                    state_d = S_IDLE;
                end else if (ready) begin
                    cnt_d = cnt_q + 17'd1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_START;
                    end
                end
            end
            S_START: state_d = S_RUN;
            S_RUN: begin
                if (btn_stop) begin
                    state_d = S_IDLE;
                end else if (song_done) begin
                    // Looping only makes sense for playback; a recording always ends.
                    state_d = (sw_loop && !record_mode_q) ? S_START : S_DONE;
                end else if (btn_pause) begin
                    state_d = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (btn_stop) begin
                    state_d = S_IDLE;
                end else if (btn_pause || btn_play) begin
                    state_d = S_RUN;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign start_song    = (state_q == S_START);
    assign song_finished = (state_q == S_DONE);
    assign pause_song    = (state_q == S_PAUSED);
    assign count_in      = (state_q == S_COUNTIN);
    assign we            = (state_q == S_RUN) && record_mode_q && ready && !song_done;
    assign record_mode   = record_mode_q;
    assign song_choice   = song_choice_q;
    assign state         = state_q;

endmodule
